// File: rtl/synth_pkg.sv
// synth_pkg: shared mixer state encoding, Q1.15 constants and 16-bit saturation helper.
package synth_pkg;

    typedef enum logic [1:0] {IDLE, MAC, GAIN, OUT} mix_state_t;

    localparam logic [15:0] Q15_ONE = 16'h8000;
    localparam logic [15:0] ENV_MAX = 16'h7FFF;
    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        return v > 64'sd32767 ? SAMPLE_MAX : v < -64'sd32768 ? SAMPLE_MIN : v[15:0];
    endfunction

endpackage

// File: rtl/voice_env_mixer_if.sv
// voice_env_mixer_if: voice/envelope inputs and mixed-sample outputs of the envelope mixer.
interface voice_env_mixer_if #(
    parameter int NUM_VOICES = 4,
    parameter int DATA_W     = 16
);
    logic                         sample_tick;
    logic [NUM_VOICES*DATA_W-1:0] voice_sample;
    logic [NUM_VOICES*DATA_W-1:0] voice_env;
    logic [DATA_W-1:0]            master_gain;
    logic [DATA_W-1:0]            out;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output sample_tick, voice_sample, voice_env, master_gain,
        input  out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, voice_sample, voice_env, master_gain,
        output out, out_valid, busy, overrun
    );
endinterface

// File: rtl/voice_env_mixer_mul.sv
// q15_mul: combinational signed multiply with arithmetic >>>15 (floor) Q1.15 rescale.
module q15_mul #(
    parameter int A_W = 19,
    parameter int B_W = 17
) (
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    output logic signed [A_W+B_W-1:0] p
);
    logic signed [A_W+B_W-1:0] full;

    assign full = a * b;
    assign p    = full >>> 15;
endmodule

// File: rtl/voice_env_mixer.sv
// voice_env_mixer: per-tick envelope-weighted sum of all voices through one shared multiplier,
// then master gain and 16-bit saturation.
module voice_env_mixer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int DATA_W     = 16
) (
    input logic               CLK,
    input logic               RESET,
    voice_env_mixer_if.slave  bus
);
    localparam int IDX_W = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;
    localparam int P_W   = ACC_W + DATA_W + 1;

    mix_state_t                   state, state_nx;
    logic [NUM_VOICES*DATA_W-1:0] samp_q, env_q;
    logic [DATA_W-1:0]            gain_q;
    logic [IDX_W-1:0]             idx;
    logic signed [ACC_W-1:0]      acc;
    logic signed [P_W-1:0]        g_q, prod;
    logic signed [DATA_W-1:0]     samp_cur;
    logic [DATA_W-1:0]            env_cur;
    logic signed [ACC_W-1:0]      mul_a;
    logic signed [DATA_W:0]       mul_b;
    logic                         tick, last;

    assign tick     = bus.sample_tick;
    assign bus.busy = state != IDLE;

    // Envelope bit 15 set means a wrapped release level, which is treated as silence.
    always_comb begin
        samp_cur = samp_q[idx*DATA_W +: DATA_W];
        env_cur  = env_q[idx*DATA_W +: DATA_W];
        last     = idx == IDX_W'(NUM_VOICES - 1);
        mul_a    = state == GAIN ? acc : ACC_W'(samp_cur);
        mul_b    = state == GAIN ? {1'b0, gain_q} : {1'b0, env_cur & {DATA_W{~env_cur[DATA_W-1]}}};
        state_nx = state == IDLE ? (tick ? MAC : IDLE)
                 : state == MAC  ? (last ? GAIN : MAC)
                 : state == GAIN ? OUT
                 : IDLE;
    end

    q15_mul #(.A_W(ACC_W), .B_W(DATA_W + 1)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            samp_q        <= '0;
            env_q         <= '0;
            gain_q        <= '0;
            idx           <= '0;
            acc           <= '0;
            g_q           <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.out_valid <= state == OUT;
            if (tick && state != IDLE)
                bus.overrun <= 1'b1;
            if (tick && state == IDLE) begin
                samp_q <= bus.voice_sample;
                env_q  <= bus.voice_env;
                gain_q <= bus.master_gain;
                acc    <= '0;
                idx    <= '0;
            end
            if (state == MAC) begin
                acc <= acc + prod[ACC_W-1:0];
                idx <= idx + 1'b1;
            end
            if (state == GAIN)
                g_q <= prod;
            if (state == OUT)
                bus.out <= sat16(64'(g_q));
        end
    end
endmodule

// File: tb/tb_voice_env_mixer.sv
// tb_voice_env_mixer: directed vectors with hand-computed mixes, latency, overrun and reset checks.
module tb_voice_env_mixer;
    import synth_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vcount;

    always #5 CLK = ~CLK;

    voice_env_mixer_if #(.NUM_VOICES(4), .DATA_W(16)) bus ();

    voice_env_mixer #(.NUM_VOICES(4), .DATA_W(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [63:0] s, input logic [63:0] e, input logic [15:0] g);
        bus.voice_sample = s;
        bus.voice_env    = e;
        bus.master_gain  = g;
    endtask

    // Pulses a tick at a negedge, optionally changes the envelopes right after, then waits
    // for out_valid and checks latency, busy duration, value and pulse width.
    task automatic do_mix(input string tag, input logic [63:0] env_after, input logic [15:0] exp);
        int k;
        int busy_cnt;
        k = 0;
        busy_cnt = 0;
        bus.sample_tick = 1'b1;
        @(negedge CLK);
        bus.sample_tick = 1'b0;
        bus.voice_env   = env_after;
        while (!bus.out_valid && k < 20) begin
            busy_cnt += int'(bus.busy);
            @(negedge CLK);
            k++;
        end
        check_val({tag, "_lat"}, k, 6);
        check_val({tag, "_busy"}, busy_cnt, 6);
        check_val({tag, "_out"}, {16'h0, bus.out}, {16'h0, exp});
        @(negedge CLK);
        check_val({tag, "_pulse"}, {31'h0, bus.out_valid}, 0);
    endtask

    initial begin
        RESET = 1'b1;
        bus.sample_tick = 1'b0;
        set_in('0, '0, Q15_ONE);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check_val("rst_out", {16'h0, bus.out}, 0);
        check_val("rst_valid", {31'h0, bus.out_valid}, 0);
        check_val("rst_busy", {31'h0, bus.busy}, 0);
        check_val("rst_ovr", {31'h0, bus.overrun}, 0);
        @(negedge CLK);

        // 0x4000 * 0x7FFF >>> 15 = 16383.5 -> floor 0x3FFF; muted voices carry nonzero samples
        set_in(64'h1234_5678_7000_4000, {48'h0, ENV_MAX}, Q15_ONE);
        do_mix("unity", {48'h0, ENV_MAX}, 16'h3FFF);

        set_in({4{16'h7FFF}}, {4{16'h7FFF}}, Q15_ONE);
        do_mix("sat_pos", {4{16'h7FFF}}, 16'h7FFF);

        set_in({4{16'h8000}}, {4{16'h7FFF}}, Q15_ONE);
        do_mix("sat_neg", {4{16'h7FFF}}, 16'h8000);

        set_in(64'h0000_0000_0000_4000, 64'h0000_0000_0000_FFF0, Q15_ONE);
        do_mix("env_wrap", 64'h0000_0000_0000_1234, 16'h0000);

        set_in(64'h0000_0000_0000_4000, 64'h0000_0000_0000_7FFF, Q15_ONE);
        do_mix("snapshot", 64'h0000_0000_0000_1234, 16'h3FFF);

        // -16384 * 32767 >>> 15 = -16383.5 -> floor -16384
        set_in(64'h0000_0000_0000_C000, 64'h0000_0000_0000_7FFF, Q15_ONE);
        do_mix("floor_neg", 64'h0000_0000_0000_7FFF, 16'hC000);

        // 0x2000 * 0x7FFF -> 8191; 8191 * 65535 >>> 15 = 16381.75 -> 16381
        set_in(64'h0000_0000_0000_2000, 64'h0000_0000_0000_7FFF, 16'hFFFF);
        do_mix("gain_max", 64'h0000_0000_0000_7FFF, 16'h3FFD);

        set_in(64'h0000_0000_0000_2000, 64'h0000_0000_0000_7FFF, 16'h0000);
        do_mix("gain_zero", 64'h0000_0000_0000_7FFF, 16'h0000);

        // Overrun: ticks at cycles 0 and 2; only the first mix produces output
        set_in(64'h0000_0000_0000_4000, {48'h0, ENV_MAX}, Q15_ONE);
        bus.sample_tick = 1'b1;
        @(negedge CLK);
        bus.sample_tick = 1'b0;
        @(negedge CLK);
        check_val("ovr_before", {31'h0, bus.overrun}, 0);
        bus.sample_tick = 1'b1;
        bus.voice_sample = 64'h0000_0000_0000_7FFF;
        @(negedge CLK);
        bus.sample_tick = 1'b0;
        check_val("ovr_set", {31'h0, bus.overrun}, 1);
        vcount = 0;
        repeat (8) begin
            @(negedge CLK);
            vcount += int'(bus.out_valid);
        end
        check_val("ovr_nvalid", vcount, 1);
        check_val("ovr_out", {16'h0, bus.out}, 32'h3FFF);
        check_val("ovr_held", {31'h0, bus.overrun}, 1);
        set_in({4{16'h7FFF}}, {4{16'h7FFF}}, Q15_ONE);
        do_mix("ovr_next", {4{16'h7FFF}}, 16'h7FFF);
        check_val("ovr_sticky", {31'h0, bus.overrun}, 1);

        // Reset mid-mix: tick at cycle 0, RESET at cycle 3, new tick at cycle 5
        set_in({4{16'h8000}}, {4{16'h7FFF}}, Q15_ONE);
        bus.sample_tick = 1'b1;
        @(negedge CLK);
        bus.sample_tick = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_val("mid_rst_out", {16'h0, bus.out}, 0);
        check_val("mid_rst_busy", {31'h0, bus.busy}, 0);
        check_val("mid_rst_ovr", {31'h0, bus.overrun}, 0);
        check_val("mid_rst_valid", {31'h0, bus.out_valid}, 0);
        @(negedge CLK);
        set_in(64'h0000_0000_0000_4000, {48'h0, ENV_MAX}, Q15_ONE);
        do_mix("after_rst", {48'h0, ENV_MAX}, 16'h3FFF);
        check_val("after_rst_ovr", {31'h0, bus.overrun}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
